instr_compressor: RTL and testbench
===================================

# instr_compressor

Stream-side pair compressor that produces the compressed instruction image consumed by the decompressor. It sits between the instruction source (loader/DMA) and program memory, scans consecutive uncompressed instruction words, and replaces every adjacent pair found in its programmable pair table with a single token word. A token word carries the opcode marker in its top bits and the byte address of the table entry in the rest, the same encoding the decompressor expands.

## Interface
- WIDTH, 32: instruction/data width.
- OPcode, 4'b1111: token marker placed in the top encodeLength bits.
- encodeLength, 4: marker width.
- SIZE, 16: number of pair entries; power of two, 2..256.
- PCADD, 32'b100: byte stride between the two words of one entry.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- wme  in  1  table write enable.
- waddr  in  $clog2(SIZE)  entry index written.
- whalf  in  1  0 = first word of pair, 1 = second word; writing whalf=1 sets the entry valid bit.
- wdata  in  WIDTH  table write data.
- in_valid  in  1  input word valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- in_data  in  WIDTH  uncompressed instruction.
- in_last  in  1  marks final word of a stream.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  WIDTH  compressed-stream word.
- tok_count  out  WIDTH  tokens emitted, wraps.
- word_count  out  WIDTH  output words emitted, wraps.
- collide  out  1  sticky: a raw input word had top bits == OPcode.

## Operation
- Token for entry i: {OPcode, (WIDTH-encodeLength)-bit value i*2*PCADD}; second word lives at token+PCADD.
- Match: entry valid && first word == held word && second word == in_data; multiple hits -> lowest index.
- FSM states EMPTY, HELD, FLUSH; hold register keeps one pending word.
- EMPTY, accept, !in_last: hold <= in_data, -> HELD, no output.
- EMPTY, accept, in_last: out <= in_data, stay EMPTY.
- HELD, accept, hit: out <= token, -> EMPTY (in_last irrelevant).
- HELD, accept, miss, !in_last: out <= hold, hold <= in_data, stay HELD.
- HELD, accept, miss, in_last: out <= hold, hold <= in_data, -> FLUSH.
- FLUSH: when output slot free, out <= hold, -> EMPTY.
- Raw words with top encodeLength bits == OPcode are forwarded unchanged and set collide; never matched as first word of a pair is not restricted.
- tok_count increments on each token handshake at output; word_count on every output handshake.

## Timing
- Reset values: state EMPTY, hold 0, out_valid 0, out_data 0, all entry valid bits 0, counters 0, collide 0; table word contents undefined.
- in_ready = (state != FLUSH) && (!out_valid || out_ready); combinational from out_ready, no other comb input->output path.
- Single output register: data appears with out_valid the cycle after the accepting edge; sustained 1 word/cycle with out_ready held high.
- out_data stable while out_valid && !out_ready.
- Table write and compare in the same cycle: compare uses pre-write contents; new contents visible next cycle.
- Reset mid-stream discards hold and output register; no word emitted.
- Counters wrap at 2^WIDTH to 0.

## Structure
- Shared package: state enum (EMPTY, HELD, FLUSH), token-build function, default OPcode/encodeLength constants also used by the decompressor.
- One sub-module: pair_cam (SIZE entries x two words + valid, write port, parallel compare, priority encoder returning hit and index).

## Test plan
- Table entry 0 = (0x00A00093, 0x00B00113) valid; stream 0x00A00093, 0x00B00113 (last) -> single output 0xF0000000, tok_count 1.
- Entry 3 loaded; stream A, B, C(last) with (A,B) missing, (B,C) = entry 3 -> outputs A then 0xF0000018.
- Empty table, stream X, Y(last) -> outputs X, Y; FLUSH holds in_ready low one output slot; word_count 2.
- out_ready low for 5 cycles during stream -> out_data stable, in_ready low, no word lost or duplicated.
- Input 0xF1234567 -> forwarded unchanged, collide stays 1 until reset.
- Assert reset with a word in HELD and out_valid high -> out_valid 0, counters 0, subsequent stream starts clean.

Source files
------------

// File: rtl/instr_compressor_pkg.sv
// ----------------------------------------------------------------------------
// instr_compressor_pkg
// Definitions shared by the pair compressor and by the matching decompressor:
//   - state_t      : compressor FSM states (EMPTY, HELD, FLUSH)
//   - DEF_*        : default data width, token marker and marker width
//   - token_offset : byte offset of a pair-table entry, i.e. the token payload
// ----------------------------------------------------------------------------
package instr_compressor_pkg;

  localparam int                    DEF_WIDTH   = 32;
  localparam int                    DEF_ENC_LEN = 4;
  localparam logic [DEF_ENC_LEN-1:0] DEF_OPCODE = 4'b1111;

  // Wide enough for any table offset; callers truncate to their payload width.
  localparam int OFF_W = 64;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // nothing pending
    HELD  = 2'd1,  // one word waiting for a possible partner
    FLUSH = 2'd2   // stream ended on a miss, held word still to be emitted
  } state_t;

  // Entry i occupies two words PCADD bytes apart, so entries are 2*PCADD
  // bytes apart and entry i starts at i*2*PCADD.
  function automatic logic [OFF_W-1:0] token_offset(input logic [OFF_W-1:0] idx,
                                                     input logic [OFF_W-1:0] pcadd);
    return (idx * pcadd) << 1;
  endfunction

endpackage

// File: rtl/instr_compressor_pair_cam.sv
// ----------------------------------------------------------------------------
// pair_cam
// SIZE-entry table of instruction pairs with a parallel compare.
//   clk, reset      : clock, asynchronous active-low reset (clears valid bits)
//   i_we            : write enable
//   i_waddr         : entry written
//   i_whalf         : 0 = first word, 1 = second word (also marks entry valid)
//   i_wdata         : word written
//   i_first         : candidate first word of a pair
//   i_second        : candidate second word of a pair
//   o_hit / o_idx   : some valid entry matches; lowest matching index
// Compare sees the contents before a same-cycle write.
// ----------------------------------------------------------------------------
module pair_cam #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 16,
  parameter int IDXW  = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [IDXW-1:0]  i_waddr,
  input  logic             i_whalf,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [WIDTH-1:0] i_first,
  input  logic [WIDTH-1:0] i_second,
  output logic             o_hit,
  output logic [IDXW-1:0]  o_idx
);

  logic [WIDTH-1:0] r_first  [SIZE];
  logic [WIDTH-1:0] r_second [SIZE];
  logic [SIZE-1:0]  r_valid;
  logic [SIZE-1:0]  w_match;

  // Word storage carries no reset; only the valid bits are meaningful at reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      if (!i_whalf) r_first[i_waddr]  <= i_wdata;
      else          r_second[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
    end else if (i_we && i_whalf) begin
      r_valid[i_waddr] <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      w_match[i] = r_valid[i] && (r_first[i] == i_first) && (r_second[i] == i_second);
    end
  end

  // Scan from the top so the lowest matching index is the one that sticks.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        o_hit = 1'b1;
        o_idx = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/instr_compressor.sv
// ----------------------------------------------------------------------------
// instr_compressor
// Replaces each adjacent input pair found in the programmable pair table by a
// single token word {OPcode, entry byte offset}; all other words pass through.
//   clk, reset                 : clock, asynchronous active-low reset
//   wme, waddr, whalf, wdata   : pair-table write port
//   in_valid/in_ready/in_data/in_last : uncompressed input stream
//   out_valid/out_ready/out_data      : compressed output stream
//   tok_count, word_count      : tokens / words handed downstream (wrapping)
//   collide                    : sticky, an input word looked like a token
//   o_state                    : current FSM state, for observation
//
// Handshake: a word moves when valid && ready are both high at a rising
// edge; valid never waits on ready, and data is held while valid && !ready.
// in_ready = (state != FLUSH) && output slot free; it is the only
// combinational input-to-output path (from out_ready).
// ----------------------------------------------------------------------------
module instr_compressor
  import instr_compressor_pkg::*;
#(
  parameter int                       WIDTH        = DEF_WIDTH,
  parameter int                       encodeLength = DEF_ENC_LEN,
  parameter logic [encodeLength-1:0]  OPcode       = DEF_OPCODE,
  parameter int                       SIZE         = 16,
  parameter logic [WIDTH-1:0]         PCADD        = WIDTH'(4)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wme,
  input  logic [$clog2(SIZE)-1:0]  waddr,
  input  logic                     whalf,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [WIDTH-1:0]         tok_count,
  output logic [WIDTH-1:0]         word_count,
  output logic                     collide,
  output state_t                   o_state
);

  localparam int IDXW = $clog2(SIZE);
  localparam int TOKW = WIDTH - encodeLength;

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_hold, w_hold_nxt;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic              r_out_tok;
  logic [WIDTH-1:0]  r_tok_count, r_word_count;
  logic              r_collide;

  logic              w_slot_free, w_accept, w_out_fire;
  logic              w_hit;
  logic [IDXW-1:0]   w_hit_idx;
  logic [TOKW-1:0]   w_tok_off;
  logic [WIDTH-1:0]  w_token;
  logic              w_load, w_load_tok;
  logic [WIDTH-1:0]  w_load_data;

  pair_cam #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE),
    .IDXW  (IDXW)
  ) u_cam (
    .clk      (clk),
    .reset    (reset),
    .i_we     (wme),
    .i_waddr  (waddr),
    .i_whalf  (whalf),
    .i_wdata  (wdata),
    .i_first  (r_hold),
    .i_second (in_data),
    .o_hit    (w_hit),
    .o_idx    (w_hit_idx)
  );

  assign w_tok_off   = TOKW'(token_offset(OFF_W'(w_hit_idx), OFF_W'(PCADD)));
  assign w_token     = {OPcode, w_tok_off};

  // The output register can take a new word if empty or draining this edge.
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_out_fire  = r_out_valid && out_ready;
  assign in_ready    = (r_state != FLUSH) && w_slot_free;
  assign w_accept    = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_load      = 1'b0;
    w_load_tok  = 1'b0;
    w_load_data = r_hold;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          if (in_last) begin
            w_load      = 1'b1;
            w_load_data = in_data;
          end else begin
            w_hold_nxt  = in_data;
            w_state_nxt = HELD;
          end
        end
      end
      HELD: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (w_hit) begin
            w_load_data = w_token;
            w_load_tok  = 1'b1;
            w_state_nxt = EMPTY;
          end else begin
            // The incoming word may still pair with the one after it.
            w_load_data = r_hold;
            w_hold_nxt  = in_data;
            w_state_nxt = in_last ? FLUSH : HELD;
          end
        end
      end
      FLUSH: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_load_data = r_hold;
          w_state_nxt = EMPTY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= EMPTY;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tok   <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_load_data;
      r_out_tok   <= w_load_tok;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tok_count  <= '0;
      r_word_count <= '0;
    end else if (w_out_fire) begin
      r_word_count <= r_word_count + WIDTH'(1);
      if (r_out_tok) r_tok_count <= r_tok_count + WIDTH'(1);
    end
  end

  // A raw word carrying the marker would be misread downstream as a token.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_collide <= 1'b0;
    end else if (w_accept && (in_data[WIDTH-1 -: encodeLength] == OPcode)) begin
      r_collide <= 1'b1;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign tok_count  = r_tok_count;
  assign word_count = r_word_count;
  assign collide    = r_collide;
  assign o_state    = r_state;

endmodule

// File: tb/tb_instr_compressor.sv
module tb_instr_compressor;
  import instr_compressor_pkg::*;

  localparam int SIZE = 16;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wme = 1'b0;
  logic [3:0]  waddr = '0;
  logic        whalf = 1'b0;
  logic [31:0] wdata = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] tok_count, word_count;
  logic        collide;
  state_t      dut_state;

  always #5 clk = ~clk;

  instr_compressor #(.SIZE(SIZE)) dut (
    .clk(clk), .reset(reset), .wme(wme), .waddr(waddr), .whalf(whalf), .wdata(wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tok_count(tok_count), .word_count(word_count), .collide(collide), .o_state(dut_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] tf [SIZE];
  logic [31:0] ts [SIZE];
  bit          tv [SIZE];
  logic [31:0] exp_q[$];
  int unsigned exp_tok = 0;
  int unsigned exp_words = 0;
  bit          exp_collide = 0;

  function automatic int lookup(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < SIZE; i++)
      if (tv[i] && tf[i] == a && ts[i] == b) return i;
    return -1;
  endfunction

  task automatic emit(input logic [31:0] w, input bit is_tok);
    exp_q.push_back(w);
    exp_words++;
    if (is_tok) exp_tok++;
  endtask

  // Greedy left-to-right pairing of a whole stream (last word = final element).
  task automatic model_stream(input logic [31:0] w[$]);
    logic [31:0] pend = '0;
    bit have = 0;
    int idx;
    for (int i = 0; i < w.size(); i++) begin
      bit last = (i == w.size() - 1);
      if (w[i][31:28] == 4'hF) exp_collide = 1;
      if (!have) begin
        if (last) emit(w[i], 0);
        else begin pend = w[i]; have = 1; end
      end else begin
        idx = lookup(pend, w[i]);
        if (idx >= 0) begin
          emit(32'hF000_0000 | 32'(idx * 8), 1);
          have = 0;
        end else begin
          emit(pend, 0);
          pend = w[i];
          if (last) begin emit(pend, 0); have = 0; end
        end
      end
    end
  endtask

  // ---------------- out_ready driver ----------------
  bit ready_mode = 0;   // 1: random back-pressure
  bit ready_fixed = 1;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_fixed;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  bit          prev_stall = 0;
  logic [31:0] prev_data = '0;
  always @(negedge clk) begin
    if (reset) begin
      if (prev_stall && out_valid) check_eq("stable_data", out_data, prev_data);
      if (out_valid && out_ready) begin
        check_eq("out_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("out_data", out_data, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    in_valid = 0; in_last = 0; wme = 0;
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1;
    exp_q.delete();
    for (int i = 0; i < SIZE; i++) tv[i] = 0;
    exp_tok = 0; exp_words = 0; exp_collide = 0;
  endtask

  task automatic write_half(input int idx, input bit half, input logic [31:0] d);
    wme = 1; waddr = 4'(idx); whalf = half; wdata = d;
    @(posedge clk); #1;
    wme = 0;
    if (!half) tf[idx] = d;
    else begin ts[idx] = d; tv[idx] = 1; end
  endtask

  task automatic write_entry(input int idx, input logic [31:0] a, input logic [31:0] b);
    write_half(idx, 0, a);
    write_half(idx, 1, b);
  endtask

  task automatic send_word(input logic [31:0] d, input bit l);
    int waited = 0;
    in_valid = 1; in_data = d; in_last = l;
    @(negedge clk);
    while (!in_ready && waited < 300) begin @(negedge clk); waited++; end
    if (!in_ready) check_eq("send_timeout", 32'(waited), 32'd0);
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic send_stream(input logic [31:0] w[$], input bit gaps);
    for (int i = 0; i < w.size(); i++) begin
      send_word(w[i], i == w.size() - 1);
      if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
      if (gaps) #1;
    end
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin @(posedge clk); waited++; end
    if (exp_q.size() != 0) check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_tok"}, tok_count, exp_tok);
    check_eq({tag, "_words"}, word_count, exp_words);
    check_eq({tag, "_collide"}, 32'(collide), 32'(exp_collide));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] s[$];
    logic [31:0] rp_a [8];
    logic [31:0] rp_b [8];
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s[$];
    logic [31:0] rp_a [8];
    logic [31:0] rp_b [8];

    do_reset();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_counts", tok_count | word_count, 32'd0);
    check_eq("rst_collide", 32'(collide), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_state", 32'(dut_state), 32'(EMPTY));

    // single pair -> one token at entry 0
    write_entry(0, 32'h00A00093, 32'h00B00113);
    emit(32'hF000_0000, 1);
    s = '{32'h00A00093, 32'h00B00113};
    send_stream(s, 0);
    drain();
    check_eq("t1_tok", tok_count, 32'd1);
    check_eq("t1_words", word_count, 32'd1);

    // (A,B) misses, (B,C) hits entry 3
    write_entry(3, 32'h00200093, 32'h00300113);
    emit(32'h00100013, 0);
    emit(32'hF000_0018, 1);
    s = '{32'h00100013, 32'h00200093, 32'h00300113};
    send_stream(s, 0);
    drain();
    check_counts("t2");

    // empty table, two raw words, FLUSH blocks input for one slot
    do_reset();
    emit(32'h12345678, 0);
    emit(32'h0BADF00D, 0);
    send_word(32'h12345678, 0);
    send_word(32'h0BADF00D, 1);
    check_eq("flush_state", 32'(dut_state), 32'(FLUSH));
    check_eq("flush_in_ready", 32'(in_ready), 32'd0);
    drain();
    check_eq("t3_words", word_count, 32'd2);
    check_eq("t3_state", 32'(dut_state), 32'(EMPTY));

    // marker-looking raw word passes through and sets the sticky flag
    s = '{32'hF1234567};
    model_stream(s);
    send_stream(s, 0);
    drain();
    check_eq("collide_set", 32'(collide), 32'd1);
    s = '{32'h00000013};
    model_stream(s);
    send_stream(s, 0);
    drain();
    check_eq("collide_sticky", 32'(collide), 32'd1);
    check_counts("t4");

    // back-pressure: out_ready low for 5 cycles mid-stream
    s.delete();
    for (int i = 0; i < 8; i++) s.push_back($urandom() & 32'h0FFF_FFFF);
    model_stream(s);
    fork
      send_stream(s, 0);
      begin
        repeat (2) @(posedge clk);
        #1 ready_fixed = 0;
        repeat (5) begin
          @(negedge clk);
          if (out_valid) check_eq("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 ready_fixed = 1;
      end
    join
    drain();
    check_counts("t5");

    // write of the second half in the same cycle as the compare is not seen
    write_half(15, 0, 32'h00C00193);
    send_word(32'h00C00193, 0);
    in_valid = 1; in_data = 32'h00D00213; in_last = 1;
    wme = 1; waddr = 4'd15; whalf = 1; wdata = 32'h00D00213;
    @(negedge clk);
    check_eq("prewrite_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 0; in_last = 0; wme = 0;
    ts[15] = 32'h00D00213; tv[15] = 1;
    emit(32'h00C00193, 0);
    emit(32'h00D00213, 0);
    drain();
    s = '{32'h00C00193, 32'h00D00213};
    model_stream(s);
    check_eq("model_tok15", exp_q[0], 32'hF000_0078);
    send_stream(s, 0);
    drain();
    check_counts("t6");

    // reset while a word is held and the output register is full
    ready_fixed = 0;
    repeat (2) @(posedge clk);
    #1;
    send_word(32'h01000013, 0);
    send_word(32'h02000013, 0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    check_eq("pre_rst_state", 32'(dut_state), 32'(HELD));
    do_reset();
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_counts", tok_count | word_count, 32'd0);
    check_eq("mid_rst_state", 32'(dut_state), 32'(EMPTY));
    ready_fixed = 1;
    repeat (2) @(posedge clk);
    #1;
    s = '{32'h00A00093, 32'h00B00113};
    model_stream(s);
    send_stream(s, 0);
    drain();
    check_eq("post_rst_words", word_count, 32'd2);
    check_eq("post_rst_tok", tok_count, 32'd0);

    // randomized streams with random back-pressure
    for (int k = 0; k < 8; k++) begin
      rp_a[k] = $urandom();
      rp_b[k] = $urandom();
      write_entry(2 * k, rp_a[k], rp_b[k]);
    end
    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      int len = $urandom_range(1, 10);
      s.delete();
      while (s.size() < len) begin
        if ($urandom_range(0, 2) == 0) begin
          int p = $urandom_range(0, 7);
          s.push_back(rp_a[p]);
          if (s.size() < len) s.push_back(rp_b[p]);
        end else begin
          s.push_back($urandom());
        end
      end
      model_stream(s);
      send_stream(s, 1);
      drain();
      check_counts("rand");
    end
    ready_mode = 0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
